sync_fifo_buf: RTL and testbench
================================

// Module: sync_fifo_buf
// PURPOSE
// - Single-clock FIFO with registered read data and 1-cycle read latency.
// - Used as a line buffer in the conv3x3 datapath. Each instance holds one
//   image row (DP = IMG_Width); two instances are cascaded for a 3-row window.
// - The producer streams one pixel per cycle. The consumer may pulse rd_en
//   on an empty FIFO while flushing the last row; such reads must be harmless.
// PARAMETERS
// - DW  default 8   data width in bits
// - DP  default 16  depth in entries; any integer >= 2, not required to be a power of 2
// - Derived localparams: AW = $clog2(DP) for the pointers, CW = $clog2(DP+1) for the occupancy count
// PORTS
// - clk    in   1   single clock; all state updates on its rising edge
// - rst    in   1   reset, synchronous, active-high; the parent connects ~rst_n
// - din    in   DW  write data
// - wr_en  in   1   write request
// - rd_en  in   1   read request
// - full   out  1   occupancy == DP (combinational from registered count)
// - empty  out  1   occupancy == 0 (combinational from registered count)
// - dout   out  DW  registered read data
// BEHAVIOUR
// - One clock, clk. Reset is synchronous and active-high.
// - Reset: wptr=0, rptr=0, count=0, dout=0. Therefore empty=1 and full=0 on
//   the cycle after rst is sampled high. Memory contents are not reset.
// - Reset mid-operation: all queued data is discarded. Behaviour then matches power-up.
// - Write accept: wr_acc = wr_en & (~full | rd_acc).
//   On wr_acc: mem[wptr] <= din; wptr advances.
// - Read accept: rd_acc = rd_en & ~empty.
//   On rd_acc: dout <= mem[rptr]; rptr advances.
//   The popped word is visible on dout in the cycle after rd_en.
// - Read when empty: ignored. dout holds its previous value, rptr is unchanged, no error is raised.
// - Write when full with no read: ignored; din is dropped and the state is unchanged.
// - Simultaneous rd_en and wr_en:
//   - Empty FIFO: only the write takes effect. There is no bypass; dout does not show din.
//   - Full FIFO: both take effect and count stays at DP.
//   - Otherwise: both take effect and count is unchanged.
// - count: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
// - Pointer wrap: ptr == DP-1 advances to 0. Explicit compare, because DP need not be 2^n.
// - Ordering: strict first-in first-out. No word is lost or duplicated across wraps.
// - dout changes only on rd_acc or on reset.
// STRUCTURE
// - Self-contained: no shared package and no sub-module.
// - Storage is a reg array mem[0:DP-1] of DW bits (inferable as distributed RAM).
// - Separate always blocks for wptr, rptr, count and dout.
// - full and empty are continuous assigns.
// TESTING
// - Reset: rst high for 2 cycles, then low -> empty=1, full=0, dout=0.
//   rd_en=1 for 3 cycles -> dout stays 0, empty stays 1.
// - Fill/drain, DP=5:
//   - Write 1,2,3,4,5 -> full=1 after the 5th write; a 6th write of 9 is dropped.
//   - Read 5 times -> dout=1,2,3,4,5, each one cycle after its rd_en.
//   - Then empty=1; a further read leaves dout=5.
// - Line-buffer streaming, DP=5:
//   - Write 10..14, with rd_en asserted together with the 5th write.
//   - Then write 15..24 with rd_en=1 every cycle -> dout sequence 10,11,12,...
//     lagging din by 5 cycles.
//   - count never exceeds 5; full is never asserted during the stream.
// - Simultaneous rd+wr on empty: wr 7 with rd_en=1 -> dout unchanged, empty=0, count=1.
//   The next read gives dout=7.
// - Simultaneous rd+wr on full, DP=5 holding 1..5: wr 6 with rd_en=1 -> dout=1, full stays 1.
//   Draining then gives 2,3,4,5,6.
// - Wrap and mid-run reset:
//   - Interleave 20 writes and reads across 4 wraps -> FIFO order preserved.
//   - Assert rst with 3 words queued -> empty=1 and dout=0 next cycle.
//   - A new write of 0xAA then reads back 0xAA.

Source files
------------

// File: rtl/sync_fifo_buf.sv
// Single-clock line-buffer FIFO with registered read data (1-cycle read latency).
// Reads on an empty FIFO are ignored so a consumer can keep pulsing rd_en while flushing.
module sync_fifo_buf #(
    parameter int DW = 8,
    parameter int DP = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] dout
);

    localparam int AW = $clog2(DP);
    localparam int CW = $clog2(DP + 1);

    localparam logic [AW-1:0] PTR_LAST = AW'(DP - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DP);

    logic [DW-1:0] mem [0:DP-1];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] dout_q;

    logic rd_acc;
    logic wr_acc;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign dout  = dout_q;

    // A write into a full FIFO is allowed only when a read frees a slot in the same cycle.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    // DP need not be a power of two, so wrap is an explicit compare.
    always_comb begin
        wptr_d = wptr_q;
        if (wr_acc) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + AW'(1);
        end
    end

    always_comb begin
        rptr_d = rptr_q;
        if (rd_acc) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + AW'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) wptr_q <= '0;
        else     wptr_q <= wptr_d;
    end

    always_ff @(posedge clk) begin
        if (rst) rptr_q <= '0;
        else     rptr_q <= rptr_d;
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    // With simultaneous read and write on a full FIFO, wptr == rptr; the read
    // sees the old word because the memory write lands at the same edge.
    always_ff @(posedge clk) begin
        if (rst)         dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rptr_q];
    end

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Bench for sync_fifo_buf (DW=8, DP=5): directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_sync_fifo_buf;

    localparam int DW = 8;
    localparam int DP = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          full;
    logic          empty;
    logic [DW-1:0] dout;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;

    sync_fifo_buf #(.DW(DW), .DP(DP)) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .full  (full),
        .empty (empty),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    // One clock with the given requests; the model follows the FIFO rules directly.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
        bit m_full, m_empty, ra, wa;
        wr_en = w; rd_en = r; din = d;
        m_full  = (q.size() == DP);
        m_empty = (q.size() == 0);
        ra = r && !m_empty;
        wa = w && (!m_full || ra);
        @(posedge clk); #1;
        if (ra) m_dout = q.pop_front();
        if (wa) q.push_back(d);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_dout = '0;
    endtask

    task automatic test_reset();
        do_reset(2);
        n_total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else n_pass++;
        n_total++; if (dout !== 8'h00) $display("FAIL reset_dout: got %0h expected 0", dout); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00);
            n_total++; if (dout !== 8'h00 || empty !== 1'b1)
                $display("FAIL reset_rd_empty[%0d]: got dout=%0h empty=%b expected dout=0 empty=1", i, dout, empty);
            else n_pass++;
        end
    endtask

    task automatic test_fill_drain();
        do_reset(1);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 8'(i));
            n_total++; if (full !== (i == 5))
                $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == 5));
            else n_pass++;
        end
        step(1'b1, 1'b0, 8'h09);
        n_total++; if (full !== 1'b1 || dout !== 8'h00)
            $display("FAIL fill_overflow: got full=%b dout=%0h expected full=1 dout=0", full, dout);
        else n_pass++;
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b1, 8'h00);
            n_total++; if (dout !== 8'(i) || dout !== m_dout)
                $display("FAIL drain_dout[%0d]: got %0h expected %0h", i, dout, i);
            else n_pass++;
        end
        n_total++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b expected 1", empty); else n_pass++;
        step(1'b0, 1'b1, 8'h00);
        n_total++; if (dout !== 8'h05) $display("FAIL drain_extra_rd: got %0h expected 5", dout); else n_pass++;
    endtask

    task automatic test_stream();
        bit saw_full = 1'b0;
        do_reset(1);
        for (int d = 10; d <= 13; d++) step(1'b1, 1'b0, 8'(d));
        for (int d = 14; d <= 24; d++) begin
            step(1'b1, 1'b1, 8'(d));
            if (full) saw_full = 1'b1;
            n_total++; if (dout !== 8'(d - 4) || dout !== m_dout)
                $display("FAIL stream_dout[din=%0d]: got %0d expected %0d", d, dout, d - 4);
            else n_pass++;
        end
        n_total++; if (saw_full !== 1'b0 || q.size() > DP)
            $display("FAIL stream_never_full: got full_seen=%b expected 0", saw_full);
        else n_pass++;
    endtask

    task automatic test_simul_empty();
        do_reset(1);
        step(1'b1, 1'b0, 8'h03);
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h07);
        n_total++; if (dout !== 8'h03 || empty !== 1'b0)
            $display("FAIL simul_empty: got dout=%0h empty=%b expected dout=3 empty=0", dout, empty);
        else n_pass++;
        step(1'b0, 1'b1, 8'h00);
        n_total++; if (dout !== 8'h07 || empty !== 1'b1)
            $display("FAIL simul_empty_rd: got dout=%0h empty=%b expected dout=7 empty=1", dout, empty);
        else n_pass++;
    endtask

    task automatic test_simul_full();
        do_reset(1);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b1, 8'h06);
        n_total++; if (dout !== 8'h01 || full !== 1'b1)
            $display("FAIL simul_full: got dout=%0h full=%b expected dout=1 full=1", dout, full);
        else n_pass++;
        for (int i = 2; i <= 6; i++) begin
            step(1'b0, 1'b1, 8'h00);
            n_total++; if (dout !== 8'(i))
                $display("FAIL simul_full_drain[%0d]: got %0h expected %0h", i, dout, i);
            else n_pass++;
        end
    endtask

    task automatic test_wrap_reset();
        do_reset(1);
        step(1'b1, 1'b0, 8'h30);
        step(1'b1, 1'b0, 8'h31);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1, 8'(8'h32 + k));
            n_total++; if (dout !== 8'(8'h30 + k))
                $display("FAIL wrap_order[%0d]: got %0h expected %0h", k, dout, 8'(8'h30 + k));
            else n_pass++;
        end
        step(1'b1, 1'b0, 8'h50);
        do_reset(1);
        n_total++; if (empty !== 1'b1 || dout !== 8'h00 || full !== 1'b0)
            $display("FAIL midrun_reset: got empty=%b full=%b dout=%0h expected 1 0 0", empty, full, dout);
        else n_pass++;
        step(1'b1, 1'b0, 8'hAA);
        step(1'b0, 1'b1, 8'h00);
        n_total++; if (dout !== 8'hAA || empty !== 1'b1)
            $display("FAIL post_reset_rd: got dout=%0h empty=%b expected aa 1", dout, empty);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset(1);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(63) == 0) begin
                do_reset(1);
            end else begin
                step(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom));
            end
            n_total++;
            if (dout !== m_dout || empty !== (q.size() == 0) || full !== (q.size() == DP)) begin
                if (errs < 10)
                    $display("FAIL random[%0d]: got dout=%0h empty=%b full=%b expected dout=%0h empty=%b full=%b",
                             i, dout, empty, full, m_dout, (q.size() == 0), (q.size() == DP));
                errs++;
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_stream();
        test_simul_empty();
        test_simul_full();
        test_wrap_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
